// File: rtl/adc_trigger_capture.sv
// Acquisition controller: decimated circular capture into the sample RAM with a
// hysteresis-qualified level trigger (or auto-trigger), frozen until the display has read it.
module adc_trigger_capture #(
  parameter int ADDR_W       = 11,
  parameter int PRE_SAMPLES  = 1024,
  parameter int HYST         = 4,
  parameter int AUTO_TIMEOUT = 0
) (
  input  logic              CLK_64MHZ,
  input  logic              MASTER_RST,
  input  logic [7:0]        ADC_DATA,
  input  logic [5:0]        TIME_BASE,
  input  logic [8:0]        TRIGGER_LEVEL,
  input  logic              TRIG_SLOPE,
  input  logic              VGA_WRITE_DONE,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [7:0]        RAM_WDATA,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              CAPTURE_DONE,
  output logic              ARMED,
  output logic [1:0]        fsm_state
);

  // RAM write port: RAM_WE qualifies RAM_WADDR/RAM_WDATA for exactly one cycle;
  // the RAM accepts every write, so there is no ready/back-pressure path.
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((1 << ADDR_W) - PRE_SAMPLES - 2);
  localparam logic [9:0]        HYST_W    = 10'(HYST);
  localparam logic [31:0]       AUTO_LAST = 32'(AUTO_TIMEOUT - 1);
  localparam bit                AUTO_EN   = (AUTO_TIMEOUT != 0);

  state_t              state_q, state_d;
  logic [5:0]          div_cnt;
  logic [ADDR_W-1:0]   wptr;
  logic [ADDR_W-1:0]   pre_cnt;
  logic [ADDR_W-1:0]   post_cnt;
  logic [31:0]         auto_cnt;
  logic                qual;

  logic                strobe;
  logic                write_en;
  logic [9:0]          sample;
  logic [9:0]          level;
  logic [9:0]          lo_thr;
  logic [9:0]          hi_thr;
  logic                qual_hit;
  logic                cross_hit;
  logic                timeout;
  logic                trig;

  always_comb begin
    strobe    = (div_cnt == TIME_BASE);
    write_en  = strobe && (state_q != S_DONE);
    sample    = {2'b00, ADC_DATA};
    level     = {1'b0, TRIGGER_LEVEL};
    // Thresholds clamp to the 9-bit code range so a level near either rail stays usable.
    lo_thr    = (level > HYST_W) ? (level - HYST_W) : 10'd0;
    hi_thr    = ((level + HYST_W) > 10'd511) ? 10'd511 : (level + HYST_W);
    qual_hit  = TRIG_SLOPE ? (sample >= hi_thr) : (sample <= lo_thr);
    cross_hit = TRIG_SLOPE ? (sample <= level) : (sample >= level);
    timeout   = AUTO_EN && (auto_cnt == AUTO_LAST);
    trig      = strobe && (state_q == S_ARMED) && ((qual && cross_hit) || timeout);
    state_d   = state_q;
    case (state_q)
      S_FILL:  if (strobe && (pre_cnt == PRE_LAST)) state_d = S_ARMED;
      S_ARMED: if (trig) state_d = S_POST;
      S_POST:  if (strobe && (post_cnt == POST_LAST)) state_d = S_DONE;
      S_DONE:  if (VGA_WRITE_DONE) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge CLK_64MHZ) begin
    if (MASTER_RST) begin
      state_q   <= S_FILL;
      div_cnt   <= '0;
      wptr      <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      auto_cnt  <= '0;
      qual      <= 1'b0;
      RAM_WE    <= 1'b0;
      RAM_WADDR <= '0;
      RAM_WDATA <= '0;
      TRIG_ADDR <= '0;
    end else begin
      state_q <= state_d;
      // Natural 6-bit overflow lets a divider above a lowered TIME_BASE run to 63 and wrap.
      div_cnt <= strobe ? 6'd0 : (div_cnt + 6'd1);
      RAM_WE  <= write_en;
      if (write_en) begin
        RAM_WADDR <= wptr;
        RAM_WDATA <= ADC_DATA;
        wptr      <= wptr + ADDR_W'(1);
      end
      case (state_q)
        S_FILL: begin
          if (strobe) begin
            pre_cnt <= pre_cnt + ADDR_W'(1);
            if (pre_cnt == PRE_LAST) begin
              qual     <= 1'b0;
              auto_cnt <= '0;
            end
          end
        end
        S_ARMED: begin
          if (strobe) begin
            auto_cnt <= auto_cnt + 32'd1;
            if (trig) begin
              qual      <= 1'b0;
              TRIG_ADDR <= wptr;
              post_cnt  <= '0;
            end else if (qual_hit) begin
              qual <= 1'b1;
            end
          end
        end
        S_POST: begin
          if (strobe) post_cnt <= post_cnt + ADDR_W'(1);
        end
        S_DONE: begin
          if (VGA_WRITE_DONE) pre_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ARMED        = (state_q == S_ARMED);
  assign CAPTURE_DONE = (state_q == S_DONE);
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Bench for adc_trigger_capture: cycle-level behavioural model with a per-cycle compare,
// plus directed scenarios pinned with hand-computed literal expectations.
module tb_adc_trigger_capture;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int HY    = 4;
  localparam int AT    = 8;

  localparam int M_FILL  = 0;
  localparam int M_ARMED = 1;
  localparam int M_POST  = 2;
  localparam int M_DONE  = 3;

  // clock / reset
  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [7:0]    adc   = 8'd0;
  logic [5:0]    tbase = 6'd0;
  logic [8:0]    level = 9'd100;
  logic          slope = 1'b0;
  logic          vga   = 1'b0;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic [AW-1:0] trig_addr;
  logic          capture_done;
  logic          armed;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  adc_trigger_capture #(
    .ADDR_W      (AW),
    .PRE_SAMPLES (PRE),
    .HYST        (HY),
    .AUTO_TIMEOUT(AT)
  ) dut (
    .CLK_64MHZ     (clk),
    .MASTER_RST    (rst),
    .ADC_DATA      (adc),
    .TIME_BASE     (tbase),
    .TRIGGER_LEVEL (level),
    .TRIG_SLOPE    (slope),
    .VGA_WRITE_DONE(vga),
    .RAM_WE        (ram_we),
    .RAM_WADDR     (ram_waddr),
    .RAM_WDATA     (ram_wdata),
    .TRIG_ADDR     (trig_addr),
    .CAPTURE_DONE  (capture_done),
    .ARMED         (armed),
    .fsm_state     (fsm_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // literal expectations queued by the stimulus, evaluated by the compare process
  string       pin_name_q[$];
  logic [31:0] pin_act_q[$];
  logic [31:0] pin_exp_q[$];
  int          pin_rd = 0;

  int hyst_vals[8]   = '{150, 150, 150, 150, 97, 100, 96, 100};
  int fall_vals[7]   = '{40, 40, 40, 40, 60, 55, 49};
  int fall2_vals[12] = '{40, 40, 40, 40, 53, 49, 40, 40, 40, 40, 40, 40};

  // behavioural model state
  int m_div = 0;
  int m_mode = M_FILL;
  int m_ptr = 0;
  int m_phase = 0;
  bit m_q = 1'b0;
  bit e_we = 1'b0;
  int e_waddr = 0;
  int e_wdata = 0;
  int e_trig = 0;

  always @(posedge clk) begin : model
    bit s_now;
    bit fire;
    bit forced;
    int smp;
    int lvl;
    int lo;
    int hi;
    if (rst) begin
      m_div = 0; m_mode = M_FILL; m_ptr = 0; m_phase = 0; m_q = 1'b0;
      e_we = 1'b0; e_waddr = 0; e_wdata = 0; e_trig = 0;
    end else begin
      s_now = (m_div == int'(tbase));
      m_div = s_now ? 0 : (m_div + 1) % 64;
      e_we  = 1'b0;
      if (m_mode == M_DONE) begin
        if (vga) begin
          m_mode  = M_FILL;
          m_phase = 0;
        end
      end else if (s_now) begin
        smp     = int'(adc);
        e_we    = 1'b1;
        e_waddr = m_ptr;
        e_wdata = smp;
        m_phase = m_phase + 1;
        if (m_mode == M_FILL) begin
          if (m_phase == PRE) begin
            m_mode = M_ARMED; m_phase = 0; m_q = 1'b0;
          end
        end else if (m_mode == M_ARMED) begin
          lvl = int'(level);
          lo  = (lvl - HY < 0) ? 0 : lvl - HY;
          hi  = (lvl + HY > 511) ? 511 : lvl + HY;
          fire   = m_q && (slope ? (smp <= lvl) : (smp >= lvl));
          forced = (AT != 0) && (m_phase == AT);
          if (fire || forced) begin
            e_trig = m_ptr; m_mode = M_POST; m_phase = 0; m_q = 1'b0;
          end else if (slope ? (smp >= hi) : (smp <= lo)) begin
            m_q = 1'b1;
          end
        end else begin
          if (m_phase == DEPTH - PRE - 1) m_mode = M_DONE;
        end
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: compare every cycle, then drain queued literal expectations
  always @(negedge clk) begin
    chk("ram_we",       32'(ram_we),       32'(e_we));
    chk("ram_waddr",    32'(ram_waddr),    32'(e_waddr));
    chk("ram_wdata",    32'(ram_wdata),    32'(e_wdata));
    chk("trig_addr",    32'(trig_addr),    32'(e_trig));
    chk("armed",        32'(armed),        32'(m_mode == M_ARMED));
    chk("capture_done", 32'(capture_done), 32'(m_mode == M_DONE));
    chk("fsm_state",    32'(fsm_state),    32'(m_mode));
    while (pin_rd < pin_act_q.size()) begin
      chk(pin_name_q[pin_rd], pin_act_q[pin_rd], pin_exp_q[pin_rd]);
      pin_rd++;
    end
  end

  // driver tasks
  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    pin_name_q.push_back(nm);
    pin_act_q.push_back(act);
    pin_exp_q.push_back(exp);
  endtask

  task do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task drive(input int v);
    adc = 8'(v);
    @(negedge clk);
  endtask

  initial begin
    // reset values
    @(negedge clk);
    @(negedge clk);
    pin("rst_we",    32'(ram_we),       32'd0);
    pin("rst_waddr", 32'(ram_waddr),    32'd0);
    pin("rst_wdata", 32'(ram_wdata),    32'd0);
    pin("rst_trig",  32'(trig_addr),    32'd0);
    pin("rst_done",  32'(capture_done), 32'd0);
    pin("rst_armed", 32'(armed),        32'd0);
    rst = 1'b0;

    // ramp: continuous writes, wrap, auto-trigger at the 8th armed strobe
    for (int k = 0; k < 24; k++) begin
      drive(k);
      pin("ramp_we", 32'(ram_we), 32'(k <= 22));
      if (k <= 22) begin
        pin("ramp_addr", 32'(ram_waddr), 32'(k % 16));
        pin("ramp_data", 32'(ram_wdata), 32'(k));
      end
      if (k == 2) pin("ramp_armed_before", 32'(armed), 32'd0);
      if (k == 3) pin("ramp_armed_after4", 32'(armed), 32'd1);
      if (k == 11) pin("ramp_auto_trig", 32'(trig_addr), 32'd11);
      if (k == 22) pin("ramp_done", 32'(capture_done), 32'd1);
    end

    // rising trigger at address 9, then 11 post writes
    level = 9'd100; slope = 1'b0;
    do_reset();
    for (int k = 0; k < 9; k++) drive(50);
    pin("rise_armed", 32'(armed), 32'd1);
    drive(100);
    pin("rise_we",    32'(ram_we),    32'd1);
    pin("rise_addr",  32'(ram_waddr), 32'd9);
    pin("rise_data",  32'(ram_wdata), 32'd100);
    pin("rise_armed_drop", 32'(armed), 32'd0);
    pin("rise_trig",  32'(trig_addr), 32'd9);
    for (int j = 1; j <= 11; j++) begin
      drive(50);
      pin("post_we",   32'(ram_we),       32'd1);
      pin("post_addr", 32'(ram_waddr),    32'((9 + j) % 16));
      pin("post_done", 32'(capture_done), 32'(j == 11));
    end
    drive(50);
    pin("done_we_off", 32'(ram_we),       32'd0);
    pin("done_high",   32'(capture_done), 32'd1);
    pin("done_trig",   32'(trig_addr),    32'd9);

    // hysteresis: 97,100 must not fire; 96,100 fires at address 7
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(hyst_vals[k]);
      if (k == 5) pin("hyst_no_fire", 32'(armed), 32'd1);
      if (k == 7) begin
        pin("hyst_fire_armed", 32'(armed),     32'd0);
        pin("hyst_fire_addr",  32'(trig_addr), 32'd7);
      end
    end

    // falling slope: 60,55,49 fires on 49
    level = 9'd50; slope = 1'b1;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(fall_vals[k]);
      if (k == 5) pin("fall_wait", 32'(armed), 32'd1);
      if (k == 6) begin
        pin("fall_fire_armed", 32'(armed),     32'd0);
        pin("fall_fire_addr",  32'(trig_addr), 32'd6);
      end
    end

    // falling slope without qualification: only the timeout ends ARMED
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(fall2_vals[k]);
      if (k == 5)  pin("fall_unqual", 32'(armed), 32'd1);
      if (k == 10) pin("fall_still_armed", 32'(armed), 32'd1);
      if (k == 11) pin("fall_timeout_addr", 32'(trig_addr), 32'd11);
    end

    // auto-trigger with unreachable level; VGA pulse in POST ignored, in DONE releases
    level = 9'd300; slope = 1'b0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(200);
      if (k == 10) pin("auto_armed", 32'(armed), 32'd1);
      if (k == 11) begin
        pin("auto_trig",  32'(trig_addr), 32'd11);
        pin("auto_armed_drop", 32'(armed), 32'd0);
      end
    end
    for (int j = 1; j <= 11; j++) begin
      vga = (j == 3);
      drive(200);
      if (j == 4) pin("vga_post_ignored", 32'(fsm_state), 32'd2);
      if (j == 11) pin("auto_done", 32'(capture_done), 32'd1);
    end
    vga = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive(200);
      pin("frozen_we",   32'(ram_we),       32'd0);
      pin("frozen_done", 32'(capture_done), 32'd1);
    end
    vga = 1'b1;
    drive(200);
    vga = 1'b0;
    pin("release_done", 32'(capture_done), 32'd0);
    pin("release_we",   32'(ram_we),       32'd0);
    drive(200);
    pin("resume_we",   32'(ram_we),    32'd1);
    pin("resume_addr", 32'(ram_waddr), 32'd7);

    // TIME_BASE=3: one write every 4th cycle; reset in POST
    tbase = 6'd3;
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      drive(k);
      if (k <= 16) pin("tb3_we", 32'(ram_we), 32'(k % 4 == 0));
      if (k <= 16 && k % 4 == 0) begin
        pin("tb3_addr", 32'(ram_waddr), 32'(k / 4 - 1));
        pin("tb3_data", 32'(ram_wdata), 32'(k));
      end
      if (k == 60) begin
        pin("tb3_in_post", 32'(fsm_state), 32'd2);
        pin("tb3_trig",    32'(trig_addr), 32'd11);
      end
    end
    rst = 1'b1;
    drive(0);
    pin("mid_rst_we",    32'(ram_we),       32'd0);
    pin("mid_rst_waddr", 32'(ram_waddr),    32'd0);
    pin("mid_rst_wdata", 32'(ram_wdata),    32'd0);
    pin("mid_rst_trig",  32'(trig_addr),    32'd0);
    pin("mid_rst_done",  32'(capture_done), 32'd0);
    pin("mid_rst_armed", 32'(armed),        32'd0);
    pin("mid_rst_state", 32'(fsm_state),    32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(100 + k);
      if (k == 3) pin("restart_idle", 32'(ram_we), 32'd0);
      if (k == 4) begin
        pin("restart_we",   32'(ram_we),    32'd1);
        pin("restart_addr", 32'(ram_waddr), 32'd0);
        pin("restart_data", 32'(ram_wdata), 32'd104);
      end
    end

    // final report
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
